// File: rtl/latex_stream_checker_if.sv
// Character stream between the LaTeX transformer (source) and the stream checker (sink).
interface latex_stream_checker_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_in, output char_valid, input char_ready);
  modport slave  (input char_in, input char_valid, output char_ready);
endinterface

// File: rtl/latex_stream_checker.sv
// Receive-side checker for the packed-ASCII LaTeX character stream.
// Compares received characters against a NUL-terminated string held as
// packed 16-bit words (high byte first) and reports match, first mismatch
// position, received length and overflow.
// Optional: define LATEX_CHECKER_CHECKSUM_EN for a mod-256 sum of accepted
// non-NUL characters; otherwise checksum is tied to zero.
module latex_stream_checker #(
  parameter int unsigned MAX_CHARS = 1023,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  latex_stream_checker_if.slave chars,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [15:0]           mem_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  match,
  output logic                  overflow,
  output logic [9:0]            err_pos,
  output logic [9:0]            char_count,
  output logic [7:0]            checksum
);

  localparam int unsigned    CNT_W    = 10;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CHARS);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(MAX_CHARS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HI    = 3'd3,
    S_LO    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state;
  state_t           state_d;
  logic             accept;
  logic             launch;
  logic [15:0]      exp_word;
  logic [7:0]       exp_byte;
  logic             is_nul;
  logic             neq;
  logic             mismatch;
  logic [CNT_W-1:0] count_inc;
  logic             at_max;

  // Per-character compare terms for the byte lane currently being consumed.
  assign exp_byte  = (state == S_HI) ? exp_word[15:8] : exp_word[7:0];
  assign is_nul    = (chars.char_in == 8'h00);
  assign neq       = (chars.char_in != exp_byte);
  assign count_inc = char_count + CNT_W'(1);
  assign at_max    = (count_inc == MAX_CNT);

  // State register plus registered handshake/status decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      chars.char_ready <= 1'b0;
    end else begin
      state            <= state_d;
      busy             <= (state_d == S_FETCH) || (state_d == S_WAIT) ||
                          (state_d == S_HI)    || (state_d == S_LO);
      done             <= (state_d == S_DONE);
      chars.char_ready <= (state_d == S_HI) || (state_d == S_LO);
    end
  end

  // Next-state logic: fetch a word, consume its two bytes, repeat until NUL or limit.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    launch  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          launch  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_HI;
      S_HI, S_LO: begin
        if (chars.char_valid) begin
          accept = 1'b1;
          if (is_nul || at_max) begin
            state_d = S_DONE;
          end else begin
            state_d = (state == S_HI) ? S_LO : S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: address walk, expected-word capture and result bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr   <= '0;
      exp_word   <= '0;
      char_count <= '0;
      err_pos    <= '0;
      mismatch   <= 1'b0;
      match      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (launch) begin
        mem_addr   <= base_addr;
        char_count <= '0;
        err_pos    <= '0;
        mismatch   <= 1'b0;
        match      <= 1'b0;
        overflow   <= 1'b0;
      end
      if (state == S_WAIT) begin
        exp_word <= mem_dout;
      end
      if (accept) begin
        char_count <= count_inc;
        if (neq && !mismatch) begin
          mismatch <= 1'b1;
          err_pos  <= char_count;
        end
        if (state == S_LO) begin
          mem_addr <= mem_addr + ADDR_W'(1);
        end
        if (is_nul) begin
          match <= ~(mismatch | neq);
          // A clean match reports err_pos equal to the final length.
          if (!(mismatch | neq)) begin
            err_pos <= count_inc;
          end
        end else if (at_max) begin
          overflow <= 1'b1;
          if (!mismatch) begin
            err_pos <= LAST_POS;
          end
        end
      end
    end
  end

`ifdef LATEX_CHECKER_CHECKSUM_EN
  // Running mod-256 sum of accepted non-NUL characters.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (launch) begin
      checksum <= '0;
    end else if (accept && !is_nul) begin
      checksum <= checksum + chars.char_in;
    end
  end
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_latex_stream_checker.sv
// Randomized self-checking bench for latex_stream_checker with a string-level reference model.
`timescale 1ns/1ps
module tb_latex_stream_checker;

  localparam int unsigned MAX_CHARS = 8;
  localparam int unsigned ADDR_W    = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_dout;
  logic              busy, done, match, overflow;
  logic [9:0]        err_pos, char_count;
  logic [7:0]        checksum;

  latex_stream_checker_if chars_if ();

  latex_stream_checker #(.MAX_CHARS(MAX_CHARS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .chars      (chars_if.slave),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .busy       (busy),
    .done       (done),
    .match      (match),
    .overflow   (overflow),
    .err_pos    (err_pos),
    .char_count (char_count),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:1023];
  always @(posedge clk) mem_dout <= mem[mem_addr];

  int checks;
  int failures;

  logic [7:0] stim[$];
  int         exp_n;
  bit         exp_match;
  bit         exp_ovf;
  int         exp_ep;
  logic [7:0] exp_cs;

  function automatic logic [7:0] get_byte(input logic [9:0] base, input int i);
    logic [15:0] w;
    w = mem[10'(int'(base) + i / 2)];
    return (i % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  function automatic void set_byte(input logic [9:0] base, input int i, input logic [7:0] b);
    logic [9:0] a;
    a = 10'(int'(base) + i / 2);
    if (i % 2 == 0) mem[a][15:8] = b;
    else            mem[a][7:0]  = b;
  endfunction

  // String-level reference: walk received chars against the stored string.
  function automatic void model(input logic [9:0] base);
    bit mis;
    logic [7:0] e;
    mis = 0; exp_n = 0; exp_match = 0; exp_ovf = 0; exp_ep = 0; exp_cs = 8'h00;
    for (int i = 0; i < stim.size(); i++) begin
      e = get_byte(base, i);
      exp_n = i + 1;
      if (!mis && stim[i] != e) begin mis = 1; exp_ep = i; end
      if (stim[i] != 8'h00) exp_cs = exp_cs + stim[i];
      if (stim[i] == 8'h00) begin
        exp_match = !mis;
        if (!mis) exp_ep = exp_n;
        return;
      end
      if (exp_n == int'(MAX_CHARS)) begin
        exp_ovf = 1;
        if (!mis) exp_ep = int'(MAX_CHARS) - 1;
        return;
      end
    end
  endfunction

  task automatic run_check(input logic [9:0] base, input bit rand_valid,
                           input bit extra_start, input string name);
    int idx;
    bit acc;
    bit got_done;
    bit holding;
    bit seq_ok;
    int words;
    logic [9:0] addrs[$];
    logic [7:0] want_cs;
    model(base);
`ifdef LATEX_CHECKER_CHECKSUM_EN
    want_cs = exp_cs;
`else
    want_cs = 8'h00;
`endif
    @(negedge clk);
    start = 1'b1; base_addr = base; chars_if.char_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    base_addr = 10'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end
    idx = 0; acc = 0; got_done = 0;
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (acc) idx++;
      if (busy && (addrs.size() == 0 || addrs[$] !== mem_addr)) addrs.push_back(mem_addr);
      if (done) begin
        got_done = 1;
      end else begin
        start = extra_start && (cyc == 2);
        if (extra_start && cyc == 2) base_addr = 10'(int'(base) + 100);
        holding = chars_if.char_valid && !acc;
        if (!holding) begin
          if (idx < exp_n) begin
            chars_if.char_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            chars_if.char_in    = stim[idx];
          end else begin
            chars_if.char_valid = 1'b0;
            chars_if.char_in    = 8'($urandom);
          end
        end
        acc = chars_if.char_valid && chars_if.char_ready;
      end
    end
    chars_if.char_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (!got_done) begin
      failures++; $display("FAIL %s timeout: accepted %0d want %0d, no done", name, idx, exp_n);
    end else if (!(acc && idx == exp_n)) begin
      failures++; $display("FAIL %s done_timing: accepted %0d want %0d, last_cycle_accept=%0b", name, idx, exp_n, acc);
    end
    if (got_done) begin
      checks++;
      if (match !== exp_match) begin
        failures++; $display("FAIL %s match: got %b want %b", name, match, exp_match);
      end
      checks++;
      if (overflow !== exp_ovf) begin
        failures++; $display("FAIL %s overflow: got %b want %b", name, overflow, exp_ovf);
      end
      checks++;
      if (err_pos !== 10'(exp_ep)) begin
        failures++; $display("FAIL %s err_pos: got %0d want %0d", name, err_pos, exp_ep);
      end
      checks++;
      if (char_count !== 10'(exp_n)) begin
        failures++; $display("FAIL %s char_count: got %0d want %0d", name, char_count, exp_n);
      end
      checks++;
      if (checksum !== want_cs) begin
        failures++; $display("FAIL %s checksum: got %h want %h", name, checksum, want_cs);
      end
      words = (exp_n + 1) / 2;
      seq_ok = (addrs.size() == words);
      for (int k = 0; k < addrs.size() && k < words; k++)
        if (addrs[k] !== 10'(int'(base) + k)) seq_ok = 0;
      checks++;
      if (!seq_ok) begin
        failures++;
        $display("FAIL %s mem_addr_seq: got %0d addrs (first %h) want %0d from %h",
                 name, addrs.size(), (addrs.size() > 0) ? addrs[0] : 10'h0, words, base);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || match !== exp_match || char_count !== 10'(exp_n)) begin
        failures++;
        $display("FAIL %s post_done_hold: done=%b busy=%b match=%b count=%0d want 0 0 %b %0d",
                 name, done, busy, match, char_count, exp_match, exp_n);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({busy, done, chars_if.char_ready, match, overflow} !== 5'b0) begin
      failures++; $display("FAIL %s flags: busy=%b done=%b ready=%b match=%b ovf=%b want all 0",
                           name, busy, done, chars_if.char_ready, match, overflow);
    end
    checks++;
    if ({err_pos, char_count, checksum, mem_addr} !== 38'b0) begin
      failures++; $display("FAIL %s values: err_pos=%0d count=%0d cs=%h addr=%h want all 0",
                           name, err_pos, char_count, checksum, mem_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  task automatic load_frac();
    mem[10'h010] = 16'h5C66;
    mem[10'h011] = 16'h7200;
  endtask

  task automatic test_directed();
    load_frac();
    stim = {8'h5C, 8'h66, 8'h72, 8'h00};
    run_check(10'h010, 1'b0, 1'b0, "frac_match");
    stim = {8'h5C, 8'h67, 8'h72, 8'h00};
    run_check(10'h010, 1'b0, 1'b0, "frac_mismatch");
    stim = {8'h5C, 8'h66, 8'h00};
    run_check(10'h010, 1'b0, 1'b0, "early_nul");
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 6; k++) mem[10'(64 + k)] = 16'h4141;
    stim.delete();
    for (int i = 0; i < 9; i++) stim.push_back(8'h41);
    run_check(10'h040, 1'b0, 1'b0, "overflow");
  endtask

  task automatic test_reset_mid();
    int idx;
    bit acc;
    bit saw_done;
    load_frac();
    stim = {8'h5C, 8'h66, 8'h72, 8'h00};
    @(negedge clk);
    start = 1'b1; base_addr = 10'h010;
    @(negedge clk);
    start = 1'b0;
    idx = 0; acc = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (acc) idx++;
      if (idx >= 2) break;
      chars_if.char_valid = 1'b1;
      chars_if.char_in    = stim[idx];
      acc = chars_if.char_valid && chars_if.char_ready;
    end
    checks++;
    if (idx != 2) begin
      failures++; $display("FAIL reset_mid accepts: got %0d want 2", idx);
    end
    rst = 1'b1; chars_if.char_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset_mid");
    saw_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      failures++; $display("FAIL reset_mid idle_after_abort: got done/busy activity want none");
    end
    run_check(10'h010, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_start_while_busy();
    load_frac();
    stim = {8'h5C, 8'h66, 8'h72, 8'h00};
    run_check(10'h010, 1'b1, 1'b1, "start_while_busy");
  endtask

  task automatic test_random();
    logic [9:0] base;
    int nulpos;
    logic [7:0] b;
    int r;
    for (int t = 0; t < 40; t++) begin
      base = (t % 5 == 0) ? 10'(1022 + t % 2) : 10'($urandom_range(0, 1023));
      for (int i = 0; i < int'(MAX_CHARS) + 2; i++) set_byte(base, i, 8'($urandom_range(33, 126)));
      if ($urandom_range(0, 3) != 0) begin
        nulpos = $urandom_range(0, int'(MAX_CHARS) + 1);
        set_byte(base, nulpos, 8'h00);
      end
      stim.delete();
      for (int i = 0; i <= int'(MAX_CHARS); i++) begin
        b = get_byte(base, i);
        r = $urandom_range(0, 9);
        if (r == 0)      b = 8'($urandom_range(33, 126));
        else if (r == 1) b = 8'h00;
        stim.push_back(b);
      end
      run_check(base, t % 2 == 1, 1'b0, $sformatf("random_%0d", t));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    chars_if.char_valid = 1'b0;
    chars_if.char_in = 8'h00;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    test_reset();
    test_directed();
    test_overflow();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/latex_stream_checker.md
Name: latex_stream_checker

Overview:
- Receive end of the packed-ASCII LaTeX character stream produced by the transformer.
- Consumes one ASCII character per handshake from the lhs or rhs byte lane.
- Fetches the expected string from the packed-character memory, starting at a given word address, and compares the two character by character.
- Reports match or mismatch, the position of the first mismatch, and the received length; used for on-chip self-test and for loopback of a second die's output.

Parameters:
- MAX_CHARS, 1023: maximum characters accepted per string, including the terminator; reaching it without a terminator ends the string as an overflow.
- ADDR_W, 10: memory word-address width.

Ports:
- clk  in  1  clock, same domain as the character source.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a check. Sampled only in IDLE.
- base_addr  in  ADDR_W  word address of the first packed word of the expected string; latched on start.
- char_in  in  8  received ASCII character.
- char_valid  in  1  char_in is valid.
- char_ready  out  1  a character is accepted on a cycle where char_valid and char_ready are both 1.
- mem_addr  out  ADDR_W  word address to the packed-character memory.
- mem_dout  in  16  memory data. Synchronous read: valid one cycle after mem_addr. High byte is the earlier character.
- busy  out  1  a check is in progress.
- done  out  1  one-cycle pulse when a check finishes.
- match  out  1  result of the last check; valid from done until the next start.
- overflow  out  1  the last check hit MAX_CHARS.
- err_pos  out  10  index of the first mismatched character (0-based); equals char_count when match=1.
- char_count  out  10  characters accepted in the last or current check, terminator included.
- checksum  out  8  see Optional Feature.

Behaviour:
- Reset: all outputs are 0 and the FSM goes to IDLE. Reset mid-check aborts immediately, with no done pulse.
- States:
  - IDLE → FETCH on start. Latch base_addr; clear word_idx, char_count, err_pos, mismatch, match, overflow, checksum. busy=1 from the cycle after start.
  - FETCH: drive mem_addr = base_addr + word_idx (wraps modulo 2^ADDR_W); go to WAIT.
  - WAIT: latch mem_dout into exp_word; go to HI.
  - HI: char_ready=1. On accept, compare char_in with exp_word[15:8]; go to LO.
  - LO: char_ready=1. On accept, compare char_in with exp_word[7:0]; word_idx++; go to FETCH.
  - DONE: for one cycle, done=1 and busy=0; then IDLE.
- char_ready is 0 in IDLE, FETCH, WAIT and DONE.
- Sustained throughput is 2 characters per 4 cycles.
- Every accept:
  - char_count++.
  - On the first inequality, set mismatch and latch err_pos = char_count (the pre-increment value).
- Once mismatch is set, comparisons and memory fetches continue but have no further effect; the FSM keeps consuming so it stays framed on the stream.
- End of string: the accepted char_in is 0x00. Next state is DONE, and match = ~mismatch, evaluated including the terminator compare.
  - An expected byte of 0x00 against a nonzero received byte is a mismatch, and consumption continues until the received NUL.
  - A received NUL against a nonzero expected byte is a mismatch and ends the check.
- Overflow: when char_count reaches MAX_CHARS on an accept without a NUL, go to DONE with overflow=1 and match=0. If err_pos was not yet latched, set it to MAX_CHARS-1.
- start while busy is ignored. char_valid while char_ready=0 is not consumed; the source must hold char_valid and char_in stable.
- A NUL arriving in HI ends the check; the unused low byte is not examined.
- Results (match, overflow, err_pos, char_count, checksum) hold until the next start.

Optional Feature:
- Macro: LATEX_CHECKER_CHECKSUM_EN.
- Defined: checksum is the modulo-256 sum of all accepted non-NUL characters, updated on each accept, cleared on start, held after done.
- Undefined: checksum is tied to 8'h00 and no adder is synthesized.

Test Plan:
1. Memory words at 0x010 hold 0x5C66 and 0x7200 ("\fr" followed by NUL); start with base_addr=0x010; send 0x5C, 0x66, 0x72, 0x00 with char_valid held high.
   → done after the 4th accept; match=1, char_count=4, err_pos=4, overflow=0; checksum=0x34 when the macro is defined.
2. Same memory; send 0x5C, 0x67, 0x72, 0x00.
   → match=0, err_pos=1, char_count=4.
3. Same memory; send 0x5C, 0x66, 0x00.
   → done after 3 accepts; match=0, err_pos=2, char_count=3.
4. MAX_CHARS=8; memory holds no 0x00 byte; send 8 chars of 0x41.
   → done after the 8th accept; overflow=1, match=0, err_pos=7.
5. Assert rst for one cycle after 2 accepts.
   → next cycle busy=0, char_ready=0, all outputs 0, and no done pulse. A following start runs a clean check.
6. Pulse start again while busy, and toggle char_valid randomly (about 50%).
   → the second start is ignored; results are identical to scenario 1; mem_addr shows 0x010 then 0x011, each held for one FETCH cycle.
